// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts words over valid/ready and streams them MSB-first
// into a serial pattern FSM, resetting that FSM for GAP cycles between words.
module serial_word_feeder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GAP   = 2,
    parameter int unsigned CNTW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             ds_rst,
    output logic             word_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    localparam logic [CNTW-1:0] CNT_WORD = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] CNT_GAP  = CNTW'(GAP - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             take_c;

    assign in_ready  = (state_q == S_IDLE) || !hold_full_q;
    assign take_c    = in_valid && in_ready;
    assign bit_out   = shift_q[WIDTH-1];
    assign bit_valid = (state_q == S_SHIFT);
    assign ds_rst    = (state_q != S_SHIFT);
    assign word_done = done_q;
    assign busy      = (state_q != S_IDLE) || hold_full_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (take_c) begin
                    shift_d = in_word;
                    cnt_d   = CNT_WORD;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_ONE;
                if (take_c) begin
                    hold_d      = in_word;
                    hold_full_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = CNT_GAP;
                    done_d  = 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == '0) begin
                    // Held word has priority; otherwise an offered word bypasses the holding register
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = CNT_WORD;
                        state_d     = S_SHIFT;
                    end else if (in_valid) begin
                        shift_d = in_word;
                        cnt_d   = CNT_WORD;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (take_c) begin
                        hold_d      = in_word;
                        hold_full_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder: word-level timing model plus expected-bit queue.
module tb_serial_word_feeder;

    localparam int unsigned W  = 32;
    localparam int unsigned G  = 2;
    localparam int unsigned CW = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_word;
    logic         in_valid;
    logic         in_ready, bit_out, bit_valid, ds_rst, word_done, busy;

    logic         rst2;
    logic [7:0]   in_word2;
    logic         in_valid2;
    logic         in_ready2, bit_out2, bit_valid2, ds_rst2, word_done2, busy2;

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(W), .GAP(G), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .ds_rst(ds_rst), .word_done(word_done), .busy(busy)
    );

    serial_word_feeder #(.WIDTH(8), .GAP(1), .CNTW(3)) dut8 (
        .clk(clk), .rst(rst2), .in_word(in_word2), .in_valid(in_valid2),
        .in_ready(in_ready2), .bit_out(bit_out2), .bit_valid(bit_valid2),
        .ds_rst(ds_rst2), .word_done(word_done2), .busy(busy2)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int t      = 0;

    // Word-level model: start cycle of the active word and of a word waiting its turn
    int   last_start = -1000;
    bit   pending    = 1'b0;
    int   pend_start = 0;
    bit   exp_ready  = 1'b1;
    bit   exp_bv     = 1'b0;
    bit   exp_done   = 1'b0;
    bit   exp_busy   = 1'b0;
    bit   mon_en     = 1'b1;
    logic exp_bits[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, t);
    endtask

    task automatic model_reset();
        last_start = -1000;
        pending    = 1'b0;
        exp_bits.delete();
    endtask

    // One clock cycle: update model for this cycle, drive inputs, account for acceptance
    task automatic cycle(input bit v, input logic [W-1:0] w, output bit acc);
        int s;
        @(negedge clk);
        t++;
        if (pending && pend_start == t) begin
            last_start = pend_start;
            pending    = 1'b0;
        end
        exp_ready = !pending;
        exp_bv    = (t >= last_start) && (t < last_start + int'(W));
        exp_done  = (t == last_start + int'(W));
        exp_busy  = pending || (t < last_start + int'(W) + int'(G));
        in_valid  = v;
        in_word   = w;
        acc       = v && exp_ready && (rst == 1'b1);
        if (acc) begin
            s = (t + 1 > last_start + int'(W) + int'(G)) ? t + 1 : last_start + int'(W) + int'(G);
            if (s == t + 1) last_start = s;
            else begin
                pending    = 1'b1;
                pend_start = s;
            end
            for (int i = W - 1; i >= 0; i--) exp_bits.push_back(w[i]);
        end
    endtask

    task automatic offer(input logic [W-1:0] w);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 200) begin
            cycle(1'b1, w, acc);
            n++;
        end
        if (!acc) chk("offer_timeout", 64'(n), 64'(0));
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, '0, acc);
    endtask

    // Monitor: per-cycle control checks and in-order bit scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            #1;
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("bit_valid", 64'(bit_valid), 64'(exp_bv));
            chk("ds_rst", 64'(ds_rst), 64'(!exp_bv));
            chk("word_done", 64'(word_done), 64'(exp_done));
            chk("busy", 64'(busy), 64'(exp_busy));
            if (bit_valid) begin
                if (exp_bits.size() == 0) chk("bit_unexpected", 64'(1), 64'(0));
                else chk("bit_out", 64'(bit_out), 64'(exp_bits.pop_front()));
            end else begin
                chk("bit_out_idle", 64'(bit_out), 64'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit           acc;
        int           s0;
        int           target;
        logic [W-1:0] cur;
        logic [17:0]  rec_bv, rec_bit, rec_done, rec_ds;

        rst       = 1'b0;
        rst2      = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        in_valid2 = 1'b0;
        in_word2  = '0;
        idle(3);
        rst  = 1'b1;
        rst2 = 1'b1;
        idle(2);

        // Single word
        offer(32'h996208E9);
        idle(40);

        // Back-to-back, then three words continuously
        offer(32'h996208E9);
        offer(32'h0975E39E);
        idle(75);
        offer(32'h12345678);
        offer(32'hDEADBEEF);
        offer(32'h0F0F00FF);
        idle(110);

        // Bypass load on the last gap cycle
        offer(32'hC0FFEE01);
        target = last_start + int'(W) + int'(G) - 1;
        while (t + 1 < target) idle(1);
        cycle(1'b1, 32'h45443871, acc);
        chk("bypass_accepted", 64'(acc), 64'(1));
        idle(40);

        // Mid-word reset with a word held
        offer(32'h51688874);
        s0 = last_start;
        offer(32'hA5A5A5A5);
        while (t + 1 < s0 + 10) idle(1);
        idle(1);
        #2 rst = 1'b0;
        #1;
        chk("rst_bit_valid", 64'(bit_valid), 64'(0));
        chk("rst_ds_rst", 64'(ds_rst), 64'(1));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_word_done", 64'(word_done), 64'(0));
        chk("rst_bit_out", 64'(bit_out), 64'(0));
        model_reset();
        idle(3);
        rst = 1'b1;
        idle(2);
        offer(32'h620D5D44);
        idle(40);

        // Random traffic; offered word changes only after acceptance
        cur = $urandom;
        repeat (600) begin
            cycle(($urandom_range(0, 2) != 0), cur, acc);
            if (acc) cur = $urandom;
        end
        idle(80);
        chk("queue_drained", 64'(exp_bits.size()), 64'(0));

        // Narrow build: WIDTH=8, GAP=1
        mon_en = 1'b0;
        @(negedge clk);
        in_valid2 = 1'b1;
        in_word2  = 8'hA5;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0) in_word2 = 8'h3C;
            if (i == 1) in_valid2 = 1'b0;
            #1;
            rec_bv[17-i]   = bit_valid2;
            rec_bit[17-i]  = bit_out2;
            rec_done[17-i] = word_done2;
            rec_ds[17-i]   = ds_rst2;
        end
        chk("w8_bit_valid", 64'(rec_bv), 64'(18'b111111110111111110));
        chk("w8_bits", 64'(rec_bit), 64'(18'b101001010001111000));
        chk("w8_word_done", 64'(rec_done), 64'(18'b000000001000000001));
        chk("w8_ds_rst", 64'(rec_ds), 64'(18'b000000001000000001));
        repeat (3) @(negedge clk);
        #1;
        chk("w8_idle_busy", 64'(busy2), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Parallel-to-serial stage that sits directly upstream of the serial-input pattern FSM.
- Accepts WIDTH-bit words over a valid/ready handshake and streams each word MSB-first, one bit per clock, onto the FSM's serial input.
- Drives the FSM's active-high reset between words, so every word is evaluated from the FSM reset state.
- Holds one pending word so back-to-back words need no upstream stall beyond the inter-word gap.

Parameters:
- WIDTH, 32, word length in bits (>=2).
- GAP, 2, cycles of downstream reset between words (>=1).
- CNTW, 5, width of the bit counter; must satisfy 2^CNTW >= WIDTH and 2^CNTW >= GAP.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_word  in  WIDTH  word to serialise.
- in_valid  in  1  in_word is valid this cycle.
- in_ready  out  1  block can accept a word this cycle.
- bit_out  out  1  serial bit; connects to the FSM serial input.
- bit_valid  out  1  high while bit_out carries a word bit.
- ds_rst  out  1  active-high reset to the downstream FSM.
- word_done  out  1  one-cycle pulse after the last bit of a word.
- busy  out  1  high when state is not IDLE or the holding register is full.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE, shift register 0, counter 0, holding register empty;
  - bit_out=0, bit_valid=0, ds_rst=1, word_done=0, in_ready=1, busy=0.
- Reset mid-word aborts the word immediately and discards any held word. No word_done is produced.
- Handshake:
  - A transfer occurs on an edge where in_valid=1 and in_ready=1.
  - in_ready is combinational: 1 in IDLE; otherwise 1 only when the holding register is empty.
  - in_word must be stable while in_valid=1 and in_ready=0.
- Outputs:
  - bit_out = shift register MSB (registered).
  - bit_valid=1 and ds_rst=0 exactly in SHIFT.
  - ds_rst=1 in IDLE and GAP.
- State IDLE:
  - On a transfer, load in_word into the shift register, set counter=WIDTH-1, go to SHIFT.
  - First bit (in_word[WIDTH-1]) appears on the cycle after the accepting edge (latency 1).
- State SHIFT:
  - Each edge shifts left by one, filling 0, and decrements the counter.
  - On the edge where counter=0: go to GAP, set counter=GAP-1, pulse word_done for that following cycle.
  - Each bit is presented for exactly one cycle, so a word occupies exactly WIDTH cycles.
  - A transfer while in SHIFT writes the holding register.
- State GAP:
  - Holds ds_rst=1 for exactly GAP cycles; the counter decrements each edge.
  - A transfer while in GAP writes the holding register.
  - On the edge where counter=0:
    - holding register full: load it into the shift register, mark the holding register empty, go to SHIFT;
    - else if in_valid=1 (in_ready is 1): bypass-load in_word directly, go to SHIFT;
    - else: go to IDLE.
- Holding register full:
  - in_ready=0 and upstream stalls until the holding register is consumed at GAP exit.
  - Never overwritten.
- Back-to-back throughput: one word per WIDTH+GAP cycles.
- The shift register and counter never wrap; the counter is reloaded only at the state transitions above.

Test Plan:
- Single word: rst low then high; transfer 0x996208E9 in IDLE.
  - Next 32 cycles: bit_out = 1,0,0,1,1,0,0,1,... matching bits 31..0, with bit_valid=1 and ds_rst=0.
  - Then word_done pulses once and ds_rst=1 for 2 cycles, then IDLE.
- Back-to-back: offer 0x996208E9 then 0x0975E39E with in_valid held high.
  - Second word is accepted during the first word's SHIFT.
  - in_ready=0 until GAP exit.
  - Second word's first bit 0 appears exactly 34 cycles after the first word's first bit.
- Hold-full stall: offer three words continuously.
  - Third word stalls (in_ready=0) until the first word's GAP ends.
  - All 96 bits are emitted in order, with no bit lost or duplicated.
- GAP-exit bypass: holding register empty and in_valid asserted only on the last GAP cycle with 0x45443871.
  - First bit 0 appears on the next cycle.
  - No IDLE cycle is inserted.
- Mid-word reset: assert rst low at bit 10 of 0x51688874.
  - Outputs immediately: bit_valid=0, ds_rst=1, in_ready=1, held word dropped, no word_done.
  - After release, a new word 0x620D5D44 serialises correctly.
- GAP=1, WIDTH=8 build: words 0xA5 then 0x3C.
  - Bit streams 10100101 and 00111100, separated by exactly 1 ds_rst cycle.
